rom_loader: RTL and testbench
=============================

# rom_loader

Program loader for the educational Harvard CPU: it writes the instruction memory that the CPU only reads. It accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them to consecutive ROM addresses. It holds the CPU control FSM in its RESET state until a frame has been loaded and its checksum has passed.

## Interface
Parameters:
- ADDR_W, 16, instruction-memory address width
- DATA_W, 16, instruction word width (fixed: two bytes per word)
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader can accept a byte; a byte transfers on a rising clk edge where rx_valid && rx_ready
- rom_we  out  1  instruction-memory write strobe, one cycle per word
- rom_addr  out  ADDR_W  write address
- rom_wdata  out  DATA_W  write word, {hi_byte, lo_byte}
- cpu_hold  out  1  forces the CPU control FSM into RESET while high
- load_ok  out  1  last frame completed with a good checksum (level)
- load_err  out  1  last frame failed its checksum (level)

## Operation
- Frame format: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words sent as HI then LO, then CHK.
- Checksum rule: the 8-bit sum, modulo 256, of every byte after SYNC, including CHK, must equal 0.
- FSM states: IDLE → (SYNC) ADDR_HI → ADDR_LO → CNT_HI → CNT_LO → DATA_HI ⇄ DATA_LO → CHECK → DONE or ERROR.
  - CNT_LO goes to CHECK when CNT == 0. Otherwise it goes to DATA_HI.
  - DATA_LO goes to CHECK after the CNT-th word. Otherwise it goes back to DATA_HI.
- In IDLE, DONE and ERROR, any non-SYNC byte is accepted and discarded.
- A SYNC byte received in DONE or ERROR starts a new frame. At that point:
  - cpu_hold rises to 1
  - load_ok and load_err clear to 0
- Inside a frame, a byte equal to SYNC is treated as ordinary data. There is no resynchronisation mid-frame.
- Address counter:
  - loaded from {ADDR_HI, ADDR_LO}
  - increments by 1 after each word write
  - wraps from 0xFFFF to 0x0000 with no error
- Word counter is 16 bits, loaded from {CNT_HI, CNT_LO}. A count of 0xFFFF is legal.
- CHECK pass: DONE, load_ok=1, cpu_hold=0.
- CHECK fail: ERROR, load_err=1, cpu_hold stays 1. Words already written are not rolled back.
- rx_ready is 1 in every state once out of reset. The loader never back-pressures the sender.

## Timing
- Reset values: rx_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, cpu_hold=1, load_ok=0, load_err=0, state=IDLE.
- rx_ready rises on the first clk edge after rst deasserts.
- Throughput: one byte per cycle, sustained. Gaps in rx_valid are allowed in any state.
- Write timing:
  - rom_we pulses high for exactly one cycle, starting the cycle after the LO byte is accepted.
  - rom_addr and rom_wdata are valid and stable during that cycle.
  - rom_addr advances on the edge that ends the write cycle.
- Write overlap: a back-to-back HI byte may be accepted during the rom_we cycle without disturbing the write in progress.
- Status latency:
  - load_ok, load_err and cpu_hold update on the edge that accepts CHK, visible the next cycle.
  - The CHK byte produces no write.
- rst asserted mid-frame: all outputs return to their reset values immediately (asynchronously). Memory contents already written are unaffected.
- Constraint: instruction memory is single-port. The CPU must not fetch while cpu_hold=1; this block guarantees rom_we=0 whenever cpu_hold=0.

## Structure
- Shared package cpu_edu_pkg holds:
  - the loader state enum (IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR)
  - SYNC_BYTE default
  - ROM address and data width constants, shared with instr_memory
- Single module with no sub-modules. The checksum accumulator, address counter and word counter are inline registers.
- Top-level integration:
  - instr_memory gains a write port (rom_we, rom_addr, rom_wdata).
  - control_unit holds in RESET while cpu_hold=1.

## Test plan
- Good frame: A5 00 00 00 02 91 05 A1 20 A7 → writes 0x9105 @0x0000 and 0xA120 @0x0001; then load_ok=1, load_err=0, cpu_hold=0.
- Bad checksum: same frame with CHK=A6 → both words still written; then load_err=1, load_ok=0, cpu_hold=1.
- Address wrap: A5 FF FF 00 02 11 11 22 22 9A → writes 0x1111 @0xFFFF and 0x2222 @0x0000; then load_ok=1.
- Empty frame and idle noise: bytes 3C 00 ahead of A5 00 10 00 00 F0 → no rom_we at any point; then load_ok=1.
- Mid-frame reset and reload: pulse rst after the first data word of the good frame → outputs at reset values immediately, cpu_hold=1; the full good frame resent afterwards gives load_ok=1.
- Stalls and reload: the good frame with rx_valid low for 3 cycles between every byte → identical writes. A second A5 sent after DONE → cpu_hold returns to 1 and load_ok clears.

Source files
------------

// File: rtl/cpu_edu_pkg.sv
// Shared definitions for the educational Harvard CPU and its program loader.
// Holds memory geometry, the loader frame marker and the loader state set.
package cpu_edu_pkg;

    localparam int ROM_ADDR_W = 16;
    localparam int ROM_DATA_W = 16;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } ld_state_e;

    function automatic logic [7:0] csum_add(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc + b;
    endfunction

endpackage

// File: rtl/rom_loader.sv
// Framed byte-stream loader that writes instruction memory and holds the
// CPU in reset until a frame with a good checksum has been loaded.
module rom_loader
    import cpu_edu_pkg::*;
#(
    parameter int          ADDR_W    = ROM_ADDR_W,
    parameter int          DATA_W    = ROM_DATA_W,
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic              cpu_hold,
    output logic              load_ok,
    output logic              load_err
);

    ld_state_e         state_q, state_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rdy_q, rdy_d;
    logic              hold_q, hold_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;

    logic              accept;
    logic [7:0]        sum_next;
    logic [15:0]       pair;

    assign accept   = rx_valid && rdy_q;
    assign sum_next = csum_add(sum_q, rx_data);
    assign pair     = {hi_q, rx_data};

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        rdy_d   = 1'b1;
        hold_d  = hold_q;
        ok_d    = ok_q;
        err_d   = err_q;

        // Address advances on the edge that closes the write cycle.
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (accept) begin
            unique case (state_q)
                IDLE, DONE, ERROR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = ADDR_HI;
                        sum_d   = 8'h00;
                        hold_d  = 1'b1;
                        ok_d    = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                ADDR_HI: begin
                    hi_d    = rx_data;
                    sum_d   = sum_next;
                    state_d = ADDR_LO;
                end
                ADDR_LO: begin
                    addr_d  = ADDR_W'(pair);
                    sum_d   = sum_next;
                    state_d = CNT_HI;
                end
                CNT_HI: begin
                    hi_d    = rx_data;
                    sum_d   = sum_next;
                    state_d = CNT_LO;
                end
                CNT_LO: begin
                    cnt_d   = pair;
                    sum_d   = sum_next;
                    state_d = (pair == 16'h0000) ? CHECK : DATA_HI;
                end
                DATA_HI: begin
                    hi_d    = rx_data;
                    sum_d   = sum_next;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    we_d    = 1'b1;
                    wdata_d = DATA_W'(pair);
                    cnt_d   = cnt_q - 16'd1;
                    sum_d   = sum_next;
                    state_d = (cnt_q == 16'd1) ? CHECK : DATA_HI;
                end
                CHECK: begin
                    sum_d = sum_next;
                    if (sum_next == 8'h00) begin
                        state_d = DONE;
                        ok_d    = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= 8'h00;
            hi_q    <= 8'h00;
            cnt_q   <= 16'h0000;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
            hold_q  <= 1'b1;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
            hold_q  <= hold_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign rx_ready  = rdy_q;
    assign rom_we    = we_q;
    assign rom_addr  = addr_q;
    assign rom_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign load_ok   = ok_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames plus random frames
// compared against a frame-level model of writes and checksum status.
module tb_rom_loader;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        rom_we;
    logic [15:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_hold;
    logic        load_ok;
    logic        load_err;

    int total = 0;
    int bad = 0;
    int hold_viol = 0;
    wq_t got;

    rom_loader dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rom_we(rom_we),
        .rom_addr(rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_hold(cpu_hold),
        .load_ok(load_ok),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_we) got.push_back({rom_addr, rom_wdata});
        if (rom_we && !cpu_hold) hold_viol++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (frame level) ----------------
    function automatic bq_t mk_frame(input logic [15:0] addr,
                                     input wq_t words, input bit corrupt);
        bq_t f;
        logic [7:0] s;
        int cnt;
        cnt = words.size();
        f.push_back(8'hA5);
        f.push_back(addr[15:8]);
        f.push_back(addr[7:0]);
        f.push_back(8'(cnt >> 8));
        f.push_back(8'(cnt));
        foreach (words[i]) begin
            f.push_back(words[i][15:8]);
            f.push_back(words[i][7:0]);
        end
        s = 8'h00;
        for (int i = 1; i < f.size(); i++) s = s + f[i];
        f.push_back(8'(256 - int'(s)) + (corrupt ? 8'h01 : 8'h00));
        return f;
    endfunction

    function automatic wq_t model_writes(input bq_t f);
        wq_t w;
        int base;
        int cnt;
        base = {f[1], f[2]};
        cnt  = {f[3], f[4]};
        for (int i = 0; i < cnt; i++)
            w.push_back({16'((base + i) % 65536), f[5 + 2*i], f[6 + 2*i]});
        return w;
    endfunction

    function automatic bit model_ok(input bq_t f);
        int s;
        s = 0;
        for (int i = 1; i < f.size(); i++) s += f[i];
        return (s % 256) == 0;
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 16) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!rx_ready) begin
            bad++;
            $display("FAIL rx_ready_timeout: rx_ready=%b required 1", rx_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input bq_t f, input int gmin, input int gmax);
        foreach (f[i]) send_byte(f[i], int'($urandom_range(gmax, gmin)));
    endtask

    task automatic settle();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rx_ready, rom_we, rom_addr, rom_wdata, cpu_hold, load_ok, load_err}
            !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: rdy=%b we=%b a=%h d=%h hold=%b ok=%b err=%b",
                     rx_ready, rom_we, rom_addr, rom_wdata, cpu_hold, load_ok, load_err);
        end
        rst = 1'b0;
        #1;
        total++;
        if (rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: got %b required 0", rx_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge: got %b required 1", rx_ready);
        end
    endtask

    task automatic run_check(input string tag, input bq_t f,
                             input int gmin, input int gmax);
        wq_t exp;
        bit  ok;
        got.delete();
        send_bytes(f, gmin, gmax);
        settle();
        exp = model_writes(f);
        ok  = model_ok(f);
        total++;
        if (got.size() != exp.size()) begin
            bad++;
            $display("FAIL %s_write_count: got %0d required %0d",
                     tag, got.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                total++;
                if (got[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL %s_write%0d: got %h required %h",
                             tag, i, got[i], exp[i]);
                end
            end
        end
        total++;
        if ({load_ok, load_err, cpu_hold} !== {ok, !ok, !ok}) begin
            bad++;
            $display("FAIL %s_status: ok/err/hold=%b%b%b required %b%b%b",
                     tag, load_ok, load_err, cpu_hold, ok, !ok, !ok);
        end
    endtask

    task automatic test_good_frame();
        bq_t f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02,
                   8'h91, 8'h05, 8'hA1, 8'h20, 8'hA7};
        run_check("good", f, 0, 0);
        total++;
        if (got.size() == 2 && got[1] !== 32'h0001_A120) begin
            bad++;
            $display("FAIL good_literal: got %h required 0001a120", got[1]);
        end
    endtask

    task automatic test_bad_checksum();
        bq_t f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02,
                   8'h91, 8'h05, 8'hA1, 8'h20, 8'hA6};
        run_check("badchk", f, 0, 0);
    endtask

    task automatic test_addr_wrap();
        bq_t f = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02,
                   8'h11, 8'h11, 8'h22, 8'h22, 8'h9A};
        run_check("wrap", f, 0, 0);
        total++;
        if (got.size() == 2 && got[1] !== 32'h0000_2222) begin
            bad++;
            $display("FAIL wrap_literal: got %h required 00002222", got[1]);
        end
    endtask

    task automatic test_empty_noise();
        bq_t f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'hF0};
        send_byte(8'h3C, 0);
        send_byte(8'h00, 0);
        run_check("empty", f, 0, 1);
    endtask

    task automatic test_mid_reset();
        bq_t head = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h91, 8'h05};
        bq_t f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02,
                   8'h91, 8'h05, 8'hA1, 8'h20, 8'hA7};
        got.delete();
        send_bytes(head, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({rx_ready, rom_we, rom_addr, rom_wdata, cpu_hold, load_ok, load_err}
            !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midrst_values: rdy=%b we=%b a=%h d=%h hold=%b ok=%b err=%b",
                     rx_ready, rom_we, rom_addr, rom_wdata, cpu_hold, load_ok, load_err);
        end
        total++;
        if (got.size() != 1 || got[0] !== 32'h0000_9105) begin
            bad++;
            $display("FAIL midrst_first_word: got %0d writes required 1 of 00009105",
                     got.size());
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_check("reload", f, 0, 0);
    endtask

    task automatic test_stalls_reload();
        bq_t f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02,
                   8'h91, 8'h05, 8'hA1, 8'h20, 8'hA7};
        bq_t rest;
        run_check("stall", f, 3, 3);
        send_byte(8'hA5, 0);
        #1;
        total++;
        if ({cpu_hold, load_ok, load_err} !== 3'b100) begin
            bad++;
            $display("FAIL resync_status: hold/ok/err=%b%b%b required 100",
                     cpu_hold, load_ok, load_err);
        end
        rest = f;
        void'(rest.pop_front());
        got.delete();
        send_bytes(rest, 0, 0);
        settle();
        total++;
        if (got.size() != 2 || load_ok !== 1'b1) begin
            bad++;
            $display("FAIL resync_finish: writes=%0d ok=%b required 2 and 1",
                     got.size(), load_ok);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            wq_t w;
            bq_t f;
            int n;
            n = int'($urandom_range(6, 0));
            for (int i = 0; i < n; i++) w.push_back(32'($urandom() & 32'hFFFF));
            f = mk_frame(16'($urandom()), w, ($urandom_range(3, 0) == 0));
            if ($urandom_range(1, 0) == 1) send_byte(8'($urandom_range(8'hA4, 0)), 0);
            run_check($sformatf("rand%0d", k), f, 0, 2);
        end
        total++;
        if (hold_viol != 0) begin
            bad++;
            $display("FAIL we_while_released: got %0d cycles required 0", hold_viol);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_addr_wrap();
        test_empty_noise();
        test_mid_reset();
        test_stalls_reload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
